// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states,
// byte-enable patterns and store-lane helpers.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Size 2'b11 falls into the word branch in both helpers.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_be = BE_BYTE0 << lo;
      SZ_HALF: store_be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: store_be = BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_wdata = {4{data[7:0]}};
      SZ_HALF: store_wdata = {2{data[15:0]}};
      default: store_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data aligner: picks the little-endian byte/half lane
// addressed by the low address bits and sign- or zero-extends it to 32 bits.
module load_extract
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bsign;
  logic        w_hsign;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte  = w_lane[i_addr_lo];
  assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_bsign = w_byte[7] & ~i_unsigned;
  assign w_hsign = w_half[15] & ~i_unsigned;

  always_comb begin
    case (i_size)
      SZ_BYTE: o_data = {{24{w_bsign}}, w_byte};
      SZ_HALF: o_data = {{16{w_hsign}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues req/ack data-memory accesses, stalls the
// pipeline until they finish, aligns load data. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_instruction,
  input  logic [31:0] mem_aluOutput,
  input  logic [31:0] mem_storeData,
  input  logic        mem_isLoad,
  input  logic        mem_isStore,
  input  logic [1:0]  mem_size,
  input  logic        mem_loadUnsigned,
  input  logic        mem_shouldWriteRegister,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        out_shouldWriteRegister,
  output logic [31:0] mem_memoryData,
  output logic        bus_error,
  output logic        misaligned_trap
);

  localparam int CW = $clog2(MAX_WAIT);

  state_t        r_state;
  state_t        w_next_state;
  logic [31:0]   r_addr;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [CW-1:0] r_wait;
  logic [31:0]   r_load_data;
  logic          r_abort;

  logic          w_mem_op;
  logic          w_misaligned;
  logic          w_trap;
  logic          w_issue;
  logic          w_ack;
  logic          w_timeout;
  logic [31:0]   w_extracted;
  logic          w_unused;

  // The instruction word is carried by the pipeline registers, not this unit.
  assign w_unused = ^mem_instruction;

  assign w_mem_op = mem_valid & (mem_isLoad | mem_isStore);

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned = ((mem_size == SZ_HALF) & mem_aluOutput[0]) |
                        (mem_size[1] & (mem_aluOutput[1:0] != 2'b00));
  assign w_trap       = (r_state == ST_IDLE) & w_mem_op & w_misaligned;
`else
  assign w_misaligned = 1'b0;
  assign w_trap       = 1'b0;
`endif

  assign w_issue   = (r_state == ST_IDLE) & w_mem_op & ~w_misaligned;
  assign w_ack     = (r_state == ST_REQ) & dmem_ack;
  assign w_timeout = (r_state == ST_REQ) & ~dmem_ack & (r_wait == CW'(MAX_WAIT - 1));

  load_extract u_load_extract (
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_rdata    (dmem_rdata),
    .o_data     (w_extracted)
  );

  always_comb begin
    w_next_state = r_state;
    mem_stall    = 1'b0;
    dmem_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          mem_stall    = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        dmem_req  = 1'b1;
        if (w_ack || w_timeout) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= BE_NONE;
      r_wdata     <= '0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_wait      <= '0;
      r_load_data <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Only a timeout sets this, so it is high exactly during the DONE that follows.
      r_abort <= w_timeout;
      if (w_issue) begin
        r_addr     <= mem_aluOutput;
        r_we       <= mem_isStore;
        r_be       <= store_be(mem_size, mem_aluOutput[1:0]);
        r_wdata    <= store_wdata(mem_size, mem_storeData);
        r_size     <= mem_size;
        r_unsigned <= mem_loadUnsigned;
        r_wait     <= '0;
      end else if (r_state == ST_REQ) begin
        r_wait <= r_wait + CW'(1);
      end
      if (w_ack && !r_we) r_load_data <= w_extracted;
      else if (w_timeout) r_load_data <= '0;
    end
  end

  assign dmem_we    = r_we;
  assign dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

  assign mem_memoryData          = r_load_data;
  assign bus_error               = r_abort;
  assign misaligned_trap         = w_trap;
  assign out_shouldWriteRegister = mem_shouldWriteRegister & ~mem_stall & ~r_abort &
                                   ~mem_isStore & ~w_trap;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against an arithmetic
// reference of lane selection, extension, byte enables and access latency.
module tb_mem_access_stage;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_isLoad, mem_isStore, mem_loadUnsigned, mem_shouldWriteRegister;
  logic [31:0] mem_instruction, mem_aluOutput, mem_storeData;
  logic [1:0]  mem_size;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, out_shouldWriteRegister, bus_error, misaligned_trap;
  logic [31:0] mem_memoryData;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_instruction(mem_instruction),
    .mem_aluOutput(mem_aluOutput), .mem_storeData(mem_storeData), .mem_isLoad(mem_isLoad),
    .mem_isStore(mem_isStore), .mem_size(mem_size), .mem_loadUnsigned(mem_loadUnsigned),
    .mem_shouldWriteRegister(mem_shouldWriteRegister), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall), .out_shouldWriteRegister(out_shouldWriteRegister),
    .mem_memoryData(mem_memoryData), .bus_error(bus_error), .misaligned_trap(misaligned_trap)
  );

  // Reference: shift the addressed lane down, mask it, then extend arithmetically.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return 4'(3 << (2 * a[1]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic go_idle();
    @(posedge clk); #1;
    mem_valid = 0; mem_isLoad = 0; mem_isStore = 0; mem_shouldWriteRegister = 0;
  endtask

  // Presents one instruction, acks on REQ cycle ack_after (0 = never), returns observations.
  task automatic run_mem(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic wr,
                         input int ack_after, input logic [31:0] rd,
                         output int n_stall, output int n_req, output logic [31:0] o_addr,
                         output logic [31:0] o_wdata, output logic [3:0] o_be, output logic o_we,
                         output logic [31:0] o_data, output logic o_wr, output logic o_berr,
                         output logic o_trap, output logic o_req_done, output logic o_stable,
                         output logic o_hung);
    @(posedge clk); #1;
    mem_valid = 1; mem_isLoad = ld; mem_isStore = st; mem_size = sz; mem_loadUnsigned = uns;
    mem_aluOutput = a; mem_storeData = sd; mem_shouldWriteRegister = wr;
    mem_instruction = $urandom;
    n_stall = 0; n_req = 0; o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0; o_data = 0;
    o_wr = 0; o_berr = 0; o_trap = 0; o_req_done = 0; o_stable = 1; o_hung = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!mem_stall) begin
        o_data = mem_memoryData; o_wr = out_shouldWriteRegister; o_berr = bus_error;
        o_trap = misaligned_trap; o_req_done = dmem_req; o_hung = 0;
        break;
      end
      n_stall++;
      if (dmem_req) begin
        n_req++;
        if (n_req == 1) begin
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
        end else if (o_addr !== dmem_addr || o_wdata !== dmem_wdata || o_be !== dmem_be ||
                     o_we !== dmem_we) begin
          o_stable = 0;
        end
        if (n_req == ack_after) begin dmem_ack = 1; dmem_rdata = rd; end
      end
      @(posedge clk); #1;
      dmem_ack = 0; dmem_rdata = $urandom;
    end
    $display("txn ld=%0d st=%0d sz=%0d addr=%h stall=%0d req=%0d data=%h wr=%0d berr=%0d",
             ld, st, sz, a, n_stall, n_req, o_data, o_wr, o_berr);
  endtask

  // Observation holders shared by the sequential test tasks.
  int ns, nr;
  logic [31:0] oa, owd, od;
  logic [3:0] obe;
  logic owe, owr, obe_err, otrap, oreqd, ostab, ohung;

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", dmem_we); end
    checks++; if (dmem_be !== 4'h0) begin errors++; $display("FAIL reset_be got=%h exp=0", dmem_be); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    checks++; if (bus_error !== 1'b0 || misaligned_trap !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got=%b%b exp=00", bus_error, misaligned_trap); end
    checks++; if (mem_memoryData !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_memoryData); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_lw_latency();
    run_mem(1, 0, 2'b10, 0, 32'h100, 0, 1, 3, 32'hDEADBEEF,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    checks++; if (ohung || ns != 4) begin errors++; $display("FAIL lw_stall got=%0d exp=4 hung=%0d", ns, ohung); end
    checks++; if (od !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", od); end
    checks++; if (owr !== 1'b1) begin errors++; $display("FAIL lw_wr got=%b exp=1", owr); end
    checks++; if (oa !== 32'h100 || obe !== 4'hF || owe !== 1'b0 || !ostab) begin
      errors++; $display("FAIL lw_bus got addr=%h be=%h we=%b stable=%0d exp 100/f/0/1", oa, obe, owe, ostab); end
    go_idle();
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs [3] = '{32'h103, 32'h103, 32'h102};
    logic [1:0]  sizes [3] = '{2'd0, 2'd0, 2'd1};
    logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    for (int i = 0; i < 3; i++) begin
      run_mem(1, 0, sizes[i], unss[i], addrs[i], 0, 1, 1, 32'h80017F00,
              ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
      checks++; if (od !== exps[i]) begin errors++; $display("FAIL load_ext[%0d] got=%h exp=%h", i, od, exps[i]); end
      checks++; if (ohung || ns != 2) begin errors++; $display("FAIL load_min_lat[%0d] got=%0d exp=2", i, ns); end
    end
    go_idle();
  endtask

  task automatic test_store();
    run_mem(0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 1, 2, 0,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    checks++; if (owe !== 1'b1 || obe !== 4'b1100) begin errors++; $display("FAIL sh_we_be got=%b/%b exp=1/1100", owe, obe); end
    checks++; if (owd !== 32'hABCDABCD || oa !== 32'h100) begin
      errors++; $display("FAIL sh_wdata_addr got=%h/%h exp=abcdabcd/00000100", owd, oa); end
    checks++; if (owr !== 1'b0) begin errors++; $display("FAIL sh_wr got=%b exp=0", owr); end
    for (int i = 0; i < 12; i++) begin
      logic [1:0] sz; logic [31:0] a, d;
      sz = 2'($urandom_range(0, 3));
      a = $urandom & ((sz == 2'd0) ? 32'hFFFFFFFF : (sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFC);
      d = $urandom;
      run_mem(0, 1, sz, 0, a, d, 1, $urandom_range(1, 4), 0,
              ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
      checks++; if (obe !== model_be(sz, a) || owd !== model_wdata(sz, d) || oa !== (a & 32'hFFFFFFFC) || owe !== 1'b1 || owr !== 1'b0) begin
        errors++; $display("FAIL rand_store[%0d] got be=%h wd=%h a=%h we=%b wr=%b exp be=%h wd=%h a=%h we=1 wr=0",
                           i, obe, owd, oa, owe, owr, model_be(sz, a), model_wdata(sz, d), a & 32'hFFFFFFFC); end
    end
    go_idle();
  endtask

  task automatic test_random_loads();
    for (int i = 0; i < 20; i++) begin
      logic [1:0] sz; logic [31:0] a, rd; logic u, w; int k;
      sz = 2'($urandom_range(0, 3)); u = 1'($urandom); w = 1'($urandom);
      a = $urandom & ((sz == 2'd0) ? 32'hFFFFFFFF : (sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFC);
      rd = $urandom; k = $urandom_range(1, 5);
      run_mem(1, 0, sz, u, a, 0, w, k, rd,
              ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
      checks++; if (od !== model_load(sz, u, a, rd) || owr !== w) begin
        errors++; $display("FAIL rand_load[%0d] got=%h wr=%b exp=%h wr=%b", i, od, owr, model_load(sz, u, a, rd), w); end
      checks++; if (ohung || ns != k + 1 || nr != k || obe !== model_be(sz, a) || !ostab) begin
        errors++; $display("FAIL rand_load_bus[%0d] got stall=%0d req=%0d be=%h stable=%0d exp stall=%0d req=%0d be=%h",
                           i, ns, nr, obe, ostab, k + 1, k, model_be(sz, a)); end
    end
    go_idle();
  endtask

  task automatic test_timeout();
    run_mem(1, 0, 2'd2, 0, 32'h200, 0, 1, 0, 0,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    checks++; if (ohung || nr != MAXW || ns != MAXW + 1) begin
      errors++; $display("FAIL timeout_len got req=%0d stall=%0d exp req=%0d stall=%0d", nr, ns, MAXW, MAXW + 1); end
    checks++; if (obe_err !== 1'b1 || oreqd !== 1'b0) begin errors++; $display("FAIL timeout_berr got=%b req=%b exp=1/0", obe_err, oreqd); end
    checks++; if (owr !== 1'b0 || od !== 32'h0) begin errors++; $display("FAIL timeout_abort got wr=%b data=%h exp 0/0", owr, od); end
    go_idle();
    @(negedge clk);
    checks++; if (bus_error !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL timeout_after got berr=%b req=%b stall=%b exp 000", bus_error, dmem_req, mem_stall); end
  endtask

  task automatic test_rst_mid_and_late_ack();
    @(posedge clk); #1;
    mem_valid = 1; mem_isLoad = 1; mem_isStore = 0; mem_size = 2'd2; mem_aluOutput = 32'h300;
    mem_shouldWriteRegister = 1;
    repeat (3) @(posedge clk);
    #1; rst = 1; mem_valid = 0; mem_isLoad = 0; mem_shouldWriteRegister = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid got req=%b stall=%b exp 0/0", dmem_req, mem_stall); end
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1; dmem_ack = 0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || mem_memoryData !== 32'h0) begin
      errors++; $display("FAIL late_ack got stall=%b req=%b data=%h exp 0/0/0", mem_stall, dmem_req, mem_memoryData); end
    run_mem(1, 0, 2'd2, 0, 32'h304, 0, 1, 1, 32'h13579BDF,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    checks++; if (ohung || ns != 2 || od !== 32'h13579BDF) begin
      errors++; $display("FAIL post_rst_lw got stall=%0d data=%h exp 2/13579bdf", ns, od); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    run_mem(1, 0, 2'd2, 0, 32'h400, 0, 1, 1, 32'h11111111,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    run_mem(1, 0, 2'd0, 1, 32'h501, 0, 1, 2, 32'h0000AB00,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    checks++; if (ohung || ns != 3 || oa !== 32'h500 || od !== 32'h000000AB) begin
      errors++; $display("FAIL b2b got stall=%0d addr=%h data=%h exp 3/00000500/000000ab", ns, oa, od); end
    run_mem(0, 0, 2'd0, 0, 32'h12345678, 0, 1, 0, 0,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
    checks++; if (ns != 0 || nr != 0 || owr !== 1'b1 || oreqd !== 1'b0) begin
      errors++; $display("FAIL passthru got stall=%0d req=%0d wr=%b exp 0/0/1", ns, nr, owr); end
    go_idle();
  endtask

  task automatic test_misaligned();
    run_mem(1, 0, 2'd2, 0, 32'h102, 0, 1, 1, 32'h89ABCDEF,
            ns, nr, oa, owd, obe, owe, od, owr, obe_err, otrap, oreqd, ostab, ohung);
`ifdef MISALIGN_TRAP_EN
    checks++; if (ns != 0 || nr != 0 || oreqd !== 1'b0 || otrap !== 1'b1 || owr !== 1'b0) begin
      errors++; $display("FAIL misalign_trap got stall=%0d req=%0d trap=%b wr=%b exp 0/0/1/0", ns, nr, otrap, owr); end
    go_idle();
    @(negedge clk);
    checks++; if (misaligned_trap !== 1'b0) begin errors++; $display("FAIL misalign_pulse got=%b exp=0", misaligned_trap); end
`else
    checks++; if (ohung || nr != 1 || oa !== 32'h100 || od !== 32'h89ABCDEF || otrap !== 1'b0) begin
      errors++; $display("FAIL misalign_pass got req=%0d addr=%h data=%h trap=%b exp 1/00000100/89abcdef/0", nr, oa, od, otrap); end
    go_idle();
`endif
  endtask

  initial begin
    rst = 1; mem_valid = 0; mem_isLoad = 0; mem_isStore = 0; mem_size = 0; mem_loadUnsigned = 0;
    mem_shouldWriteRegister = 0; mem_instruction = 0; mem_aluOutput = 0; mem_storeData = 0;
    dmem_ack = 0; dmem_rdata = 0;
    test_reset();
    test_lw_latency();
    test_load_extend();
    test_store();
    test_random_loads();
    test_timeout();
    test_rst_mid_and_late_ack();
    test_back_to_back();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
